// File: rtl/cpu6_fetch_unit_pkg.sv
// Shared defaults and helpers for the cpu6 fetch stage.
package cpu6_fetch_unit_pkg;

  localparam int unsigned DefXlen     = 32;
  localparam int unsigned DefDepth    = 4;
  localparam int unsigned DefMaxOutst = 2;
  localparam int unsigned DefResetPc  = 0;
  localparam int unsigned PcInc       = 4;

  // A request may issue only if the response it produces is guaranteed a queue slot.
  function automatic logic reqCredit(input int unsigned count, input int unsigned outst,
                                     input int unsigned depth, input int unsigned maxOutst);
    return (outst < maxOutst) && ((count + outst) < depth);
  endfunction

endpackage

// File: rtl/cpu6_fetch_unit_if.sv
// Fetch-stage bus: imem request/response, EX redirect and decode handshake.
interface cpu6_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_instr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            busy;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, busy,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_instr, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, busy,
    output imem_req_ready, imem_rsp_valid, imem_rsp_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/cpu6_fetch_fifo.sv
// Synchronous FIFO for fetched {pc,instr} entries, with single-cycle flush.
module cpu6_fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           popData,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wrPtrQ, rdPtrQ;
  logic [CntW-1:0]  cntQ;
  logic             doPush, doPop;

  function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    doPop  = pop && (cntQ != '0);
    doPush = push && ((cntQ != CntW'(DEPTH)) || doPop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      cntQ   <= '0;
    end else if (flush) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      cntQ   <= '0;
    end else begin
      if (doPush) wrPtrQ <= nextPtr(wrPtrQ);
      if (doPop)  rdPtrQ <= nextPtr(rdPtrQ);
      cntQ <= cntQ + CntW'(doPush) - CntW'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !flush) mem[wrPtrQ] <= pushData;
  end

  assign popData = mem[rdPtrQ];
  assign empty   = (cntQ == '0);
  assign count   = cntQ;

`ifndef SYNTHESIS
  noOverflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !flush && (cntQ == CntW'(DEPTH)) && !pop));
`endif

endmodule

// File: rtl/cpu6_fetch_unit.sv
// cpu6 fetch stage: PC-ordered imem requests, response queue, redirect flush.
// Define CPU6_FETCH_BYPASS_EN to let a response reach decode in the same cycle when the queue is empty.
module cpu6_fetch_unit
  import cpu6_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN      = DefXlen,
  parameter int unsigned     DEPTH     = DefDepth,
  parameter int unsigned     MAX_OUTST = DefMaxOutst,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DefResetPc)
) (
  input logic              clk,
  input logic              reset,
  cpu6_fetch_unit_if.master bus
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned OstW = $clog2(MAX_OUTST + 1);
  localparam int unsigned EntW = 2 * XLEN;

  logic [XLEN-1:0] fetchPcQ, fetchPcD, rspPcQ, rspPcD, redirTarget;
  logic [OstW-1:0] outstQ, outstD, dropQ, dropD;
  logic [CntW-1:0] fifoCount;
  logic [EntW-1:0] fifoHead;
  logic            fifoEmpty, fifoPush, fifoPop;
  logic            reqValid, reqFire, rspKeep, bypassHit;

  cpu6_fetch_fifo #(
    .WIDTH(EntW),
    .DEPTH(DEPTH)
  ) uFifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (bus.redirect_valid),
    .push    (fifoPush),
    .pushData({rspPcQ, bus.imem_rsp_instr}),
    .pop     (fifoPop),
    .popData (fifoHead),
    .empty   (fifoEmpty),
    .count   (fifoCount)
  );

  always_comb begin
    redirTarget = bus.redirect_pc & ~XLEN'(3);
    reqValid    = reset && !bus.redirect_valid &&
                  reqCredit(int'(fifoCount), int'(outstQ), DEPTH, MAX_OUTST);
    reqFire     = reqValid && bus.imem_req_ready;
    rspKeep     = bus.imem_rsp_valid && (dropQ == '0) && !bus.redirect_valid;
`ifdef CPU6_FETCH_BYPASS_EN
    bypassHit     = rspKeep && fifoEmpty;
    bus.out_valid = reset && !bus.redirect_valid && (!fifoEmpty || bypassHit);
    {bus.out_pc, bus.out_instr} = bypassHit ? {rspPcQ, bus.imem_rsp_instr} : fifoHead;
`else
    bypassHit     = 1'b0;
    bus.out_valid = reset && !bus.redirect_valid && !fifoEmpty;
    {bus.out_pc, bus.out_instr} = fifoHead;
`endif
    fifoPop  = bus.out_valid && bus.out_ready && !fifoEmpty;
    // A bypassed response that decode takes immediately never occupies a slot.
    fifoPush = rspKeep && !(bypassHit && bus.out_ready);
  end

  always_comb begin
    fetchPcD = fetchPcQ;
    rspPcD   = rspPcQ;
    outstD   = outstQ;
    dropD    = dropQ;
    if (bus.redirect_valid) begin
      fetchPcD = redirTarget;
      rspPcD   = redirTarget;
      outstD   = outstQ - OstW'(bus.imem_rsp_valid);
      dropD    = outstQ - OstW'(bus.imem_rsp_valid);
    end else begin
      if (reqFire) fetchPcD = fetchPcQ + XLEN'(PcInc);
      if (rspKeep) rspPcD = rspPcQ + XLEN'(PcInc);
      outstD = outstQ + OstW'(reqFire) - OstW'(bus.imem_rsp_valid);
      if (bus.imem_rsp_valid && (dropQ != '0)) dropD = dropQ - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetchPcQ <= RESET_PC;
      rspPcQ   <= RESET_PC;
      outstQ   <= '0;
      dropQ    <= '0;
    end else begin
      fetchPcQ <= fetchPcD;
      rspPcQ   <= rspPcD;
      outstQ   <= outstD;
      dropQ    <= dropD;
    end
  end

  assign bus.imem_req_valid = reqValid;
  assign bus.imem_req_addr  = fetchPcQ;
  assign bus.busy           = (outstQ != '0) || (dropQ != '0);

`ifndef SYNTHESIS
  outstNoOverflow: assert property (@(posedge clk) disable iff (!reset)
    !(reqFire && !bus.imem_rsp_valid && (outstQ == OstW'(MAX_OUTST))));
  rspOnlyWhenOutst: assert property (@(posedge clk) disable iff (!reset)
    bus.imem_rsp_valid |-> (outstQ != '0));
`endif

endmodule

// File: tb/tb_cpu6_fetch_unit.sv
// Randomized bench for cpu6_fetch_unit: epoch-tagged imem model plus expected decode stream.
module tb_cpu6_fetch_unit;

  localparam int unsigned Depth    = 4;
  localparam int unsigned MaxOutst = 2;

  typedef struct {logic [31:0] addr; int epoch; int due;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;

  logic clk = 1'b0;
  logic reset;
  cpu6_fetch_unit_if #(.XLEN(32)) bif ();

  cpu6_fetch_unit dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  int          nAssert = 0, nFail = 0;
  int          cyc = 0, epoch = 0, lastDue = 0;
  req_t        pend[$];
  ent_t        expQ[$];
  logic [31:0] expFetch;
  logic [31:0] popLog[$], accLog[$];
  int          popCycLog[$];
  int          firstRspCyc = -1, firstOutCyc = -1;
  int          readyPct = 100, outReadyPct = 100, redirPct = 0, latMin = 1, latMax = 1;
  bit          forceRedir = 0, redirOnRsp = 0, redirOnRspHit = 0;
  logic [31:0] forceRedirPc, redirOnRspPc;

  function automatic logic [31:0] memFn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    pend.delete();
    expQ.delete();
    popLog.delete();
    popCycLog.delete();
    accLog.delete();
    expFetch    = 32'h0;
    epoch++;
    lastDue     = cyc;
    firstRspCyc = -1;
    firstOutCyc = -1;
  endtask

  task automatic driveIdle();
    bif.imem_req_ready = 1'b0;
    bif.imem_rsp_valid = 1'b0;
    bif.imem_rsp_instr = 32'h0;
    bif.redirect_valid = 1'b0;
    bif.redirect_pc    = 32'h0;
    bif.out_ready      = 1'b0;
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic step();
    bit          rspNow, redir, keep, byp, expReqV, expOutV, accept, pop;
    logic [31:0] redirPc;
    ent_t        head, e;
    req_t        r;
    int          lat, due;
    @(negedge clk);
    rspNow = (pend.size() > 0) && (pend[0].due <= cyc);
    bif.imem_req_ready = (int'($urandom_range(0, 99)) < readyPct);
    bif.imem_rsp_valid = rspNow;
    bif.imem_rsp_instr = rspNow ? memFn(pend[0].addr) : $urandom;
    bif.out_ready      = (int'($urandom_range(0, 99)) < outReadyPct);
    redirPc = $urandom;
    redir   = (int'($urandom_range(0, 99)) < redirPct);
    if (forceRedir) begin
      redir = 1;
      redirPc = forceRedirPc;
      forceRedir = 0;
    end else if (redirOnRsp && rspNow && expQ.size() > 0) begin
      redir = 1;
      redirPc = redirOnRspPc;
      bif.out_ready = 1'b1;
      redirOnRsp = 0;
      redirOnRspHit = 1;
    end
    bif.redirect_valid = redir;
    bif.redirect_pc    = redirPc;
    #1;
    keep    = rspNow && !redir && (pend[0].epoch == epoch);
    expReqV = !redir && (pend.size() < MaxOutst) && ((expQ.size() + pend.size()) < Depth);
    byp     = 0;
`ifdef CPU6_FETCH_BYPASS_EN
    byp = keep && (expQ.size() == 0);
`endif
    expOutV = !redir && ((expQ.size() > 0) || byp);
    check("req_valid", bif.imem_req_valid, expReqV);
    check("req_addr", bif.imem_req_addr, expFetch);
    check("out_valid", bif.out_valid, expOutV);
    check("busy", bif.busy, pend.size() != 0);
    if (expOutV) begin
      if (byp) head = '{pc: pend[0].addr, instr: memFn(pend[0].addr)};
      else head = expQ[0];
      check("out_pc", bif.out_pc, head.pc);
      check("out_instr", bif.out_instr, head.instr);
    end
    if (keep && firstRspCyc < 0) firstRspCyc = cyc;
    if (bif.out_valid === 1'b1 && firstOutCyc < 0) firstOutCyc = cyc;
    accept = expReqV && bif.imem_req_ready;
    pop    = expOutV && bif.out_ready;
    if (redir) begin
      epoch++;
      expQ.delete();
      popLog.delete();
      popCycLog.delete();
      accLog.delete();
      expFetch = redirPc & ~32'h3;
      if (rspNow) void'(pend.pop_front());
    end else begin
      if (pop && !byp) begin
        e = expQ.pop_front();
        popLog.push_back(e.pc);
        popCycLog.push_back(cyc);
      end
      if (rspNow) begin
        r = pend.pop_front();
        if (keep) begin
          e = '{pc: r.addr, instr: memFn(r.addr)};
          if (byp && bif.out_ready) begin
            popLog.push_back(e.pc);
            popCycLog.push_back(cyc);
          end else expQ.push_back(e);
        end
      end
      if (accept) begin
        lat = int'($urandom_range(latMin, latMax));
        due = (cyc + lat > lastDue + 1) ? cyc + lat : lastDue + 1;
        lastDue = due;
        pend.push_back('{addr: expFetch, epoch: epoch, due: due});
        accLog.push_back(expFetch);
        expFetch = expFetch + 32'd4;
      end
    end
    cyc++;
  endtask

  // Reset asserted `offset` ns after a falling edge, i.e. not aligned to the rising edge.
  task automatic asyncReset(input int offset);
    @(negedge clk);
    driveIdle();
    #(offset);
    reset = 1'b0;
    #1;
    check("rst_req_valid", bif.imem_req_valid, 1'b0);
    check("rst_out_valid", bif.out_valid, 1'b0);
    check("rst_busy", bif.busy, 1'b0);
    check("rst_addr", bif.imem_req_addr, 32'h0);
    @(negedge clk);
    modelReset();
    reset = 1'b1;
    #1;
    check("first_req_after_rst", bif.imem_req_valid, 1'b1);
  endtask

  task automatic setKnobs(input int rdy, input int ordy, input int rpct, input int lmin,
                          input int lmax);
    readyPct = rdy;
    outReadyPct = ordy;
    redirPct = rpct;
    latMin = lmin;
    latMax = lmax;
  endtask

  initial begin
    driveIdle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("init_req_valid", bif.imem_req_valid, 1'b0);
    check("init_out_valid", bif.out_valid, 1'b0);
    check("init_busy", bif.busy, 1'b0);
    check("init_addr", bif.imem_req_addr, 32'h0);
    modelReset();
    reset = 1'b1;
    #1;
    check("first_req_after_rst", bif.imem_req_valid, 1'b1);

    // 1: single-cycle imem, decode always ready -> back-to-back sequential pcs.
    setKnobs(100, 100, 0, 1, 1);
    repeat (12) step();
    check("t1_pc0", popLog[0], 32'h0);
    check("t1_pc1", popLog[1], 32'h4);
    check("t1_pc2", popLog[2], 32'h8);
    check("t1_pc3", popLog[3], 32'hC);
    check("t1_consecutive", popCycLog[3] - popCycLog[0], 32'd3);
`ifdef CPU6_FETCH_BYPASS_EN
    check("t6_latency", firstOutCyc - firstRspCyc, 32'd0);
`else
    check("t6_latency", firstOutCyc - firstRspCyc, 32'd1);
`endif

    // 2: latency 3 with decode stalled -> credit stops at exactly Depth requests.
    asyncReset(3);
    setKnobs(100, 0, 0, 3, 3);
    repeat (20) step();
    check("t2_req_count", accLog.size(), 32'd4);
    check("t2_req_low", bif.imem_req_valid, 1'b0);
    outReadyPct = 100;
    repeat (12) step();
    check("t2_pc0", popLog[0], 32'h0);
    check("t2_pc3", popLog[3], 32'hC);
    check("t2_pc4", popLog[4], 32'h10);

    // 3: redirect with two requests in flight.
    asyncReset(2);
    setKnobs(100, 100, 0, 3, 3);
    for (int i = 0; i < 50 && pend.size() != 2; i++) step();
    check("t3_two_inflight", pend.size(), 32'd2);
    forceRedirPc = 32'h100;
    forceRedir = 1;
    repeat (20) step();
    check("t3_first_pc", popLog[0], 32'h100);

    // 4: redirect coinciding with a response and a pop.
    asyncReset(4);
    setKnobs(100, 0, 0, 2, 2);
    repeat (3) step();
    outReadyPct = 100;
    redirOnRspPc = 32'h202;
    redirOnRsp = 1;
    for (int i = 0; i < 50 && !redirOnRspHit; i++) step();
    check("t4_hit", redirOnRspHit, 1'b1);
    redirOnRsp = 0;
    repeat (15) step();
    check("t4_first_pc", popLog[0], 32'h200);

    // 6: PC wrap at the top of the address space.
    setKnobs(100, 100, 0, 1, 1);
    forceRedirPc = 32'hFFFF_FFFC;
    forceRedir = 1;
    repeat (8) step();
    check("t6_acc0", accLog[0], 32'hFFFF_FFFC);
    check("t6_acc1", accLog[1], 32'h0);
    check("t6_pop1", popLog[1], 32'h0);

    // 5: asynchronous reset in the middle of random traffic.
    setKnobs(70, 60, 0, 1, 4);
    repeat (30) step();
    asyncReset(1);
    setKnobs(100, 100, 0, 1, 1);
    repeat (10) step();
    check("t5_restart_pc", popLog[0], 32'h0);

    // Random soak with occasional redirects.
    setKnobs(60, 60, 3, 1, 4);
    repeat (2000) step();
    setKnobs(100, 100, 0, 1, 1);
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
